// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART receive path.
//   - rx_state_t      : receiver FSM encodings (IDLE/START/DATA/PARITY/STOP)
//   - OVERSAMPLE_DEF,
//     DATA_BITS_DEF   : default frame geometry
//   - MAJ_LO/MID/HI   : majority sample indices for the default oversample rate.
//                       maj_lo/maj_mid/maj_hi() give the same values for any
//                       other rate.
//   - rx_dec_t        : frame decision handed from the FSM to the output stage
//   - maj3()          : 2-of-3 majority vote
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 8;

    // Bit centre is at OVERSAMPLE/2; vote on the tick before, at and after it.
    localparam int MAJ_MID = OVERSAMPLE_DEF / 2;
    localparam int MAJ_LO  = MAJ_MID - 1;
    localparam int MAJ_HI  = MAJ_MID + 1;

    function automatic int maj_mid(input int os);
        return os / 2;
    endfunction

    function automatic int maj_lo(input int os);
        return os / 2 - 1;
    endfunction

    function automatic int maj_hi(input int os);
        return os / 2 + 1;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // vld: a frame was decided this cycle; ok: its stop bit was 1
    typedef struct packed {
        logic vld;
        logic ok;
    } rx_dec_t;

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
//   Two-flop synchronizer for an asynchronous, idle-high input, plus a
//   registered falling-edge detect. Both flops reset to 1 so that reset
//   release on an idle line never looks like an edge.
//
//   Ports:
//     clk       in   system clock
//     rst_n     in   asynchronous active-low reset
//     async_in  in   asynchronous input
//     sync_out  out  synchronized level
//     fall      out  1 on the first clk that sync_out reads 0 after a 1
// -----------------------------------------------------------------------------
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out,
    output logic fall
);

    logic meta;

    // fall is computed from the same inputs that produce the next sync_out,
    // so the pulse lines up with the first low cycle of sync_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta     <= 1'b1;
            sync_out <= 1'b1;
            fall     <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
            fall     <= sync_out & ~meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   8N1 UART receiver. RXD is synchronized, oversampled on sample_tick, and
//   each bit is decided by a 2-of-3 vote around the bit centre. A completed
//   byte is held in rx_data with rx_valid until rx_ack.
//
//   Optional feature macro: UART_RX_PARITY_EN
//     defined   -> adds parity_odd/parity_err and a parity bit after the data
//     undefined -> plain 8N1, neither port exists
//
//   Ports:
//     clk          in   system clock
//     rst_n        in   asynchronous active-low reset
//     sample_tick  in   one-clk pulse at OVERSAMPLE x baud
//     RXD          in   serial line (async, idle high)
//     parity_odd   in   (parity build) 1 = odd parity, 0 = even
//     parity_err   out  (parity build) pulse alongside delivery/overrun
//     rx_data      out  received byte, stable while rx_valid
//     rx_valid     out  byte available, held until rx_ack
//     rx_ack       in   consumer accepts the byte
//     frame_err    out  one-clk pulse: stop bit sampled 0, byte discarded
//     overrun      out  one-clk pulse: new byte dropped, old byte unread
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_tick,
    input  logic                 RXD,
`ifdef UART_RX_PARITY_EN
    input  logic                 parity_odd,
    output logic                 parity_err,
`endif
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] T_LO   = TW'(maj_lo(OVERSAMPLE));
    localparam logic [TW-1:0] T_MID  = TW'(maj_mid(OVERSAMPLE));
    localparam logic [TW-1:0] T_HI   = TW'(maj_hi(OVERSAMPLE));
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    logic                 rxs;
    logic                 rx_fall;
    rx_state_t            state;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 smp_lo;
    logic                 smp_mid;
    rx_dec_t              dec_q;
    logic                 maj;
    logic                 at_hi;
    logic                 wrap;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit;
    logic                 dec_perr;
`endif

    uart_rx_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (RXD),
        .sync_out (rxs),
        .fall     (rx_fall)
    );

    // The third vote is the live sample taken on the decision tick itself.
    assign maj   = maj3(smp_lo, smp_mid, rxs);
    assign at_hi = (tick_cnt == T_HI);
    assign wrap  = (tick_cnt == T_LAST);

    // -------------------------------------------------------------------------
    // Frame FSM. dec_q is a one-cycle strobe carrying the stop-bit outcome to
    // the output stage; shreg is not touched again until the next frame's
    // DATA phase, so the output stage can read it on the following clk.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            smp_lo   <= 1'b1;
            smp_mid  <= 1'b1;
            dec_q    <= '0;
`ifdef UART_RX_PARITY_EN
            par_bit  <= 1'b0;
            dec_perr <= 1'b0;
`endif
        end else begin
            dec_q.vld <= 1'b0;
            case (state)
                IDLE: begin
                    // sample_tick is irrelevant here; only the line edge matters
                    if (rx_fall) begin
                        tick_cnt <= '0;
                        state    <= START;
                    end
                end
                default: begin
                    if (sample_tick) begin
                        tick_cnt <= wrap ? '0 : tick_cnt + 1'b1;
                        if (tick_cnt == T_LO)  smp_lo  <= rxs;
                        if (tick_cnt == T_MID) smp_mid <= rxs;

                        case (state)
                            START: begin
                                if (at_hi && maj) begin
                                    state <= IDLE;          // glitch, not a start bit
                                end else if (wrap) begin
                                    state   <= DATA;
                                    bit_cnt <= '0;
                                end
                            end
                            DATA: begin
                                if (at_hi)
                                    shreg <= {maj, shreg[DATA_BITS-1:1]};
                                if (wrap) begin
                                    if (bit_cnt == B_LAST) begin
`ifdef UART_RX_PARITY_EN
                                        state <= PARITY;
`else
                                        state <= STOP;
`endif
                                    end else begin
                                        bit_cnt <= bit_cnt + 1'b1;
                                    end
                                end
                            end
`ifdef UART_RX_PARITY_EN
                            PARITY: begin
                                if (at_hi) par_bit <= maj;
                                if (wrap)  state   <= STOP;
                            end
`endif
                            STOP: begin
                                // Leave at mid-stop so the next start edge is
                                // caught even if the sender's clock runs fast.
                                if (at_hi) begin
                                    state     <= IDLE;
                                    dec_q.vld <= 1'b1;
                                    dec_q.ok  <= maj;
`ifdef UART_RX_PARITY_EN
                                    // XOR over data+parity must equal parity_odd
                                    dec_perr  <= (^shreg) ^ par_bit ^ parity_odd;
`endif
                                end
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Holding register. An ack arriving on the delivery clk frees the slot in
    // the same cycle, so the new byte replaces the old one without overrun.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (rx_valid && rx_ack)
                rx_valid <= 1'b0;

            if (dec_q.vld) begin
                if (!dec_q.ok) begin
                    frame_err <= 1'b1;
                end else if (!rx_valid || rx_ack) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                    parity_err <= dec_perr;
`endif
                end else begin
                    overrun <= 1'b1;
`ifdef UART_RX_PARITY_EN
                    parity_err <= dec_perr;
`endif
                end
            end
        end
    end

endmodule
